// File: rtl/serial_parity_receiver_pkg.sv
// serial_parity_receiver_pkg: FSM state encoding and parity-sense constants shared by the serial link blocks.
package serial_parity_receiver_pkg;
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;
endpackage

// File: rtl/serial_parity_receiver_acc.sv
// parity_acc: 1-bit XOR accumulator with clear and enable; clear wins over enable.
module parity_acc (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_bit,
  output logic o_acc
);
  logic r_acc;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_acc <= 1'b0;
    else if (i_clr) r_acc <= 1'b0;
    else if (i_en) r_acc <= r_acc ^ i_bit;
  assign o_acc = r_acc;
endmodule

// File: rtl/serial_parity_receiver.sv
// serial_parity_receiver: deserializes start/data/parity/stop frames and delivers word plus error flags on valid/ready.
module serial_parity_receiver
  import serial_parity_receiver_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              sin,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);
  localparam int CW = $clog2(DATA_W + 1);
  state_t            r_state, w_next;
  logic [DATA_W-1:0] r_shreg, r_dout;
  logic [DATA_W:0]   w_shift;
  logic [CW-1:0]     r_cnt;
  logic              r_perr, w_acc;
  logic              r_dout_valid, r_parity_err, r_frame_err, r_overrun;
  logic              w_start, w_data, w_parity, w_commit, w_block, w_last;
  assign w_start  = bit_en & (r_state == S_IDLE) & ~sin;
  assign w_data   = bit_en & (r_state == S_DATA);
  assign w_parity = bit_en & (r_state == S_PARITY);
  assign w_commit = bit_en & (r_state == S_STOP);
  assign w_block  = r_dout_valid & ~dout_ready;
  assign w_last   = r_cnt == CW'(DATA_W - 1);
  assign w_shift  = {sin, r_shreg};
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (bit_en)
      w_next = r_state == S_IDLE   ? (sin ? S_IDLE : S_DATA) :
               r_state == S_DATA   ? (w_last ? S_PARITY : S_DATA) :
               r_state == S_PARITY ? S_STOP : S_IDLE;
  end
  parity_acc u_acc (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_start),
    .i_en  (w_data),
    .i_bit (sin),
    .o_acc (w_acc)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_shreg <= '0;
      r_cnt   <= '0;
      r_perr  <= 1'b0;
    end else begin
      if (w_start) r_cnt <= '0;
      if (w_data) begin
        r_shreg <= w_shift[DATA_W:1];
        r_cnt   <= r_cnt + 1'b1;
      end
      if (w_parity) r_perr <= w_acc ^ sin ^ PARITY_ODD;
    end
  // A full, unaccepted output register drops the new frame and flags it instead.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_overrun <= w_commit & w_block;
      if (w_commit && !w_block) begin
        r_dout       <= r_shreg;
        r_parity_err <= r_perr;
        r_frame_err  <= ~sin;
        r_dout_valid <= 1'b1;
      end else if (r_dout_valid && dout_ready) r_dout_valid <= 1'b0;
    end
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign busy       = r_state != S_IDLE;
endmodule

// File: tb/tb_serial_parity_receiver.sv
// tb_serial_parity_receiver: scoreboard bench for an even-parity and an odd-parity receiver sharing one serial line.
module tb_serial_parity_receiver;
  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst, bit_en, sin, dout_ready;
  logic [7:0] dout, o_dout;
  logic       dout_valid, parity_err, frame_err, overrun, busy;
  logic       o_valid, o_perr, o_ferr, o_ovr, o_busy;
  exp_t       exp_q[$];
  int         checks = 0, errors = 0, n_ovr = 0;
  bit         rnd_gap = 1'b0;
  always #5 clk = ~clk;
  serial_parity_receiver dut (
    .clk(clk), .rst(rst), .bit_en(bit_en), .sin(sin), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );
  serial_parity_receiver #(.PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .rst(rst), .bit_en(bit_en), .sin(sin), .dout(o_dout), .dout_valid(o_valid),
    .dout_ready(dout_ready), .parity_err(o_perr), .frame_err(o_ferr), .overrun(o_ovr), .busy(o_busy)
  );
  always @(negedge clk) if (!rst && overrun) n_ovr++;
  always @(negedge clk)
    if (!rst && dout_valid && dout_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: unexpected word %h, none expected", dout);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({dout, parity_err, frame_err} !== {e.data, e.perr, e.ferr}) begin
          errors++;
          $display("FAIL scoreboard: got %h perr=%b ferr=%b want %h perr=%b ferr=%b",
                   dout, parity_err, frame_err, e.data, e.perr, e.ferr);
        end
        checks++;
        if ({o_valid, o_dout, o_perr, o_ferr} !== {1'b1, e.data, ~e.perr, e.ferr}) begin
          errors++;
          $display("FAIL odd_scoreboard: got v=%b %h perr=%b ferr=%b want v=1 %h perr=%b ferr=%b",
                   o_valid, o_dout, o_perr, o_ferr, e.data, ~e.perr, e.ferr);
        end
      end
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic strobe(input logic b, input bit rdy);
    int g;
    g = rnd_gap ? int'($urandom_range(1, 7)) : 4;
    sin = b;
    bit_en = 1'b0;
    repeat (g - 1) tick();
    bit_en = 1'b1;
    if (rdy) dout_ready = 1'b1;
    tick();
    bit_en = 1'b0;
  endtask
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop,
                            input bit push, input bit rdy_at_stop);
    if (push) exp_q.push_back('{d, ^d ^ pbit, ~stop});
    strobe(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) strobe(d[i], 1'b0);
    strobe(pbit, 1'b0);
    strobe(stop, rdy_at_stop);
    sin = 1'b1;
  endtask
  task automatic test_reset();
    rst = 1'b1; bit_en = 1'b0; sin = 1'b1; dout_ready = 1'b1;
    repeat (2) tick();
    checks++;
    if ({dout, dout_valid, parity_err, frame_err, overrun, busy} !== 13'd0) begin
      errors++;
      $display("FAIL reset: outputs %h want 0", {dout, dout_valid, parity_err, frame_err, overrun, busy});
    end
    rst = 1'b0;
    tick();
  endtask
  task automatic test_frame(input logic [7:0] d, input logic pbit, input logic stop);
    send_frame(d, pbit, stop, 1'b1, 1'b0);
    checks++;
    if (dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency_%h: dout_valid=%b want 1", d, dout_valid);
    end
    tick();
    checks++;
    if (dout_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL valid_drop_%h: dout_valid=%b busy=%b want 0 0", d, dout_valid, busy);
    end
  endtask
  task automatic test_overrun();
    int n0;
    n0 = n_ovr;
    dout_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({overrun, dout_valid, dout} !== {2'b11, 8'h11}) begin
      errors++;
      $display("FAIL overrun_pulse: ovr=%b v=%b dout=%h want 1 1 11", overrun, dout_valid, dout);
    end
    tick();
    checks++;
    if ({overrun, dout_valid, dout} !== {2'b01, 8'h11}) begin
      errors++;
      $display("FAIL overrun_hold: ovr=%b v=%b dout=%h want 0 1 11", overrun, dout_valid, dout);
    end
    dout_ready = 1'b1;
    tick();
    checks++;
    if (dout_valid !== 1'b0 || n_ovr - n0 != 1) begin
      errors++;
      $display("FAIL overrun_drain: v=%b pulses=%0d want 0 1", dout_valid, n_ovr - n0);
    end
  endtask
  task automatic test_mid_reset();
    strobe(1'b0, 1'b0);
    repeat (4) strobe(1'b1, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_mid: busy=%b want 1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({dout, dout_valid, parity_err, frame_err, overrun, busy, o_busy} !== 14'd0) begin
      errors++;
      $display("FAIL mid_reset: outputs %h want 0", {dout, dout_valid, parity_err, frame_err, overrun, busy, o_busy});
    end
    tick();
    rst = 1'b0;
    sin = 1'b1;
    tick();
    test_frame(8'h81, 1'b0, 1'b1);
  endtask
  task automatic test_back_to_back();
    int n0;
    n0 = n_ovr;
    rnd_gap = 1'b1;
    dout_ready = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({dout_valid, dout, overrun, o_perr, parity_err} !== {1'b1, 8'hC3, 3'b010}) begin
      errors++;
      $display("FAIL commit_accept: v=%b dout=%h ovr=%b odd_perr=%b perr=%b want 1 c3 0 1 0",
               dout_valid, dout, overrun, o_perr, parity_err);
    end
    tick();
    checks++;
    if (dout_valid !== 1'b0 || n_ovr != n0) begin
      errors++;
      $display("FAIL back_to_back_end: v=%b extra_overruns=%0d want 0 0", dout_valid, n_ovr - n0);
    end
    rnd_gap = 1'b0;
  endtask
  initial begin
    test_reset();
    test_frame(8'hA5, 1'b0, 1'b1);
    test_frame(8'hA5, 1'b1, 1'b1);
    test_frame(8'h3C, 1'b0, 1'b0);
    test_overrun();
    test_mid_reset();
    test_back_to_back();
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL undelivered: %0d words still expected, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
